// File: rtl/vending_if.sv
// vending_if: front-panel / actuator bundle of the vending controller.
//   coin_valid, coin        coin acceptor strobe + denomination code (0=1,1=2,2=5,3=10)
//   coin_reject             one-cycle pulse: last strobed coin returned
//   sel_valid, sel          selection key strobe + item index
//   sel_err                 one-cycle pulse: selection refused
//   cancel, restock         refund request, stock reload
//   out, out_item           dispense pulse and the item being dispensed
//   change_valid/_coin/_ready  change payout handshake
//   credit, sold_out, busy  status
//
// Handshake: change_coin is offered while change_valid=1 and stays stable
// until the rising edge where change_valid && change_ready are both high;
// that edge transfers exactly one coin. Strobes (coin_valid, sel_valid) are
// single-cycle and carry no ready; refusal is reported by coin_reject/sel_err.
interface vending_if #(
    parameter int N_ITEMS = 4,
    parameter int PRICE_W = 8
);
    localparam int SEL_W = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1;

    logic                coin_valid;
    logic [1:0]          coin;
    logic                coin_reject;
    logic                sel_valid;
    logic [SEL_W-1:0]    sel;
    logic                sel_err;
    logic                cancel;
    logic                restock;
    logic                out;
    logic [SEL_W-1:0]    out_item;
    logic                change_valid;
    logic [1:0]          change_coin;
    logic                change_ready;
    logic [PRICE_W-1:0]  credit;
    logic [N_ITEMS-1:0]  sold_out;
    logic                busy;

    // Controller side
    modport slave (
        input  coin_valid, coin, sel_valid, sel, cancel, restock, change_ready,
        output coin_reject, sel_err, out, out_item, change_valid, change_coin,
               credit, sold_out, busy
    );

    // Front panel / actuator side
    modport master (
        output coin_valid, coin, sel_valid, sel, cancel, restock, change_ready,
        input  coin_reject, sel_err, out, out_item, change_valid, change_coin,
               credit, sold_out, busy
    );
endinterface

// File: rtl/vending_controller.sv
// vending_controller: multi-item vending controller with saturating credit,
// per-item stock, cancel/refund and greedy one-coin-per-handshake change.
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous active-low reset
//   bus      vending_if.slave (coin, selection, dispense, change, status)
//   state_o  debug view of the FSM state (IDLE=0, CREDIT=1, VEND=2, CHANGE=3)
// All bus outputs come straight from flops.
module vending_controller #(
    parameter int                          N_ITEMS    = 4,
    parameter int                          PRICE_W    = 8,
    parameter logic [N_ITEMS*PRICE_W-1:0]  PRICES     = {8'd20, 8'd15, 8'd10, 8'd5},
    parameter int                          MAX_CREDIT = 100,
    parameter int                          STOCK_W    = 4,
    parameter int                          INIT_STOCK = 15
) (
    input  logic        clk,
    input  logic        rst,
    vending_if.slave    bus,
    output logic [1:0]  state_o
);
    localparam int SEL_W = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1;
    localparam int CW    = PRICE_W + 1;
    localparam logic [CW-1:0]      MAX_C      = CW'(MAX_CREDIT);
    localparam logic [SEL_W:0]     N_LIMIT    = (SEL_W + 1)'(N_ITEMS);
    localparam logic [STOCK_W-1:0] STOCK_INIT = STOCK_W'(INIT_STOCK);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CREDIT = 2'd1,
        S_VEND   = 2'd2,
        S_CHANGE = 2'd3
    } state_e;

    function automatic logic [PRICE_W-1:0] coin_value(input logic [1:0] c);
        case (c)
            2'd0:    return PRICE_W'(1);
            2'd1:    return PRICE_W'(2);
            2'd2:    return PRICE_W'(5);
            default: return PRICE_W'(10);
        endcase
    endfunction

    // Largest denomination not exceeding the remaining credit.
    function automatic logic [1:0] greedy_code(input logic [PRICE_W-1:0] c);
        if (c >= PRICE_W'(10))     return 2'd3;
        else if (c >= PRICE_W'(5)) return 2'd2;
        else if (c >= PRICE_W'(2)) return 2'd1;
        else                       return 2'd0;
    endfunction

    state_e               state_q, state_d;
    logic [PRICE_W-1:0]   credit_q, credit_d;
    logic [STOCK_W-1:0]   stock_q [N_ITEMS];
    logic [STOCK_W-1:0]   stock_d [N_ITEMS];
    logic                 out_q, out_d;
    logic [SEL_W-1:0]     out_item_q, out_item_d;
    logic                 coin_reject_q, coin_reject_d;
    logic                 sel_err_q, sel_err_d;
    logic                 change_valid_q, change_valid_d;
    logic [1:0]           change_coin_q, change_coin_d;
    logic [N_ITEMS-1:0]   sold_out_q, sold_out_d;
    logic                 busy_q, busy_d;

    logic [PRICE_W-1:0]   price_a [N_ITEMS];
    logic [PRICE_W-1:0]   sel_price;
    logic [STOCK_W-1:0]   sel_stock;
    logic                 sel_in_range;
    logic [CW-1:0]        coin_sum;

    for (genvar g = 0; g < N_ITEMS; g++) begin : g_price
        assign price_a[g] = PRICES[g*PRICE_W +: PRICE_W];
    end

    // Lookup by comparison so an out-of-range sel never indexes past the arrays.
    always_comb begin
        sel_price = '0;
        sel_stock = '0;
        for (int i = 0; i < N_ITEMS; i++) begin
            if (bus.sel == SEL_W'(i)) begin
                sel_price = price_a[i];
                sel_stock = stock_q[i];
            end
        end
    end

    assign sel_in_range = ({1'b0, bus.sel} < N_LIMIT);
    assign coin_sum     = {1'b0, credit_q} + {1'b0, coin_value(bus.coin)};

    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        stock_d       = stock_q;
        out_item_d    = out_item_q;
        coin_reject_d = 1'b0;
        sel_err_d     = 1'b0;

        case (state_q)
            S_IDLE, S_CREDIT: begin
                if (state_q == S_IDLE && bus.restock) begin
                    for (int i = 0; i < N_ITEMS; i++) stock_d[i] = STOCK_INIT;
                end
                // cancel > sel_valid > coin_valid; cancel only counts with credit
                if (bus.cancel && credit_q != '0) begin
                    state_d       = S_CHANGE;
                    coin_reject_d = bus.coin_valid;
                end else if (bus.sel_valid) begin
                    coin_reject_d = bus.coin_valid;
                    if (sel_in_range && sel_stock != '0 && credit_q >= sel_price) begin
                        credit_d   = credit_q - sel_price;
                        out_item_d = bus.sel;
                        state_d    = S_VEND;
                    end else begin
                        sel_err_d = 1'b1;
                    end
                end else if (bus.coin_valid) begin
                    if (coin_sum <= MAX_C) begin
                        credit_d = coin_sum[PRICE_W-1:0];
                        state_d  = S_CREDIT;
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end
            end
            S_VEND: begin
                coin_reject_d = bus.coin_valid;
                for (int i = 0; i < N_ITEMS; i++) begin
                    if (out_item_q == SEL_W'(i)) stock_d[i] = stock_q[i] - STOCK_W'(1);
                end
                state_d = (credit_q != '0) ? S_CHANGE : S_IDLE;
            end
            S_CHANGE: begin
                coin_reject_d = bus.coin_valid;
                if (bus.change_ready) begin
                    credit_d = credit_q - coin_value(change_coin_q);
                    if (credit_d == '0) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they land in flops.
        out_d          = (state_d == S_VEND);
        busy_d         = (state_d == S_VEND) || (state_d == S_CHANGE);
        change_valid_d = (state_d == S_CHANGE);
        change_coin_d  = change_valid_d ? greedy_code(credit_d) : 2'd0;
        for (int i = 0; i < N_ITEMS; i++) sold_out_d[i] = (stock_d[i] == '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            credit_q       <= '0;
            for (int i = 0; i < N_ITEMS; i++) stock_q[i] <= STOCK_INIT;
            out_q          <= 1'b0;
            out_item_q     <= '0;
            coin_reject_q  <= 1'b0;
            sel_err_q      <= 1'b0;
            change_valid_q <= 1'b0;
            change_coin_q  <= 2'd0;
            sold_out_q     <= '0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            stock_q        <= stock_d;
            out_q          <= out_d;
            out_item_q     <= out_item_d;
            coin_reject_q  <= coin_reject_d;
            sel_err_q      <= sel_err_d;
            change_valid_q <= change_valid_d;
            change_coin_q  <= change_coin_d;
            sold_out_q     <= sold_out_d;
            busy_q         <= busy_d;
        end
    end

    assign bus.coin_reject  = coin_reject_q;
    assign bus.sel_err      = sel_err_q;
    assign bus.out          = out_q;
    assign bus.out_item     = out_item_q;
    assign bus.change_valid = change_valid_q;
    assign bus.change_coin  = change_coin_q;
    assign bus.credit       = credit_q;
    assign bus.sold_out     = sold_out_q;
    assign bus.busy         = busy_q;
    assign state_o          = state_q;
endmodule

// File: tb/tb_vending_controller.sv
module tb_vending_controller;
    localparam int N    = 4;
    localparam int MAXC = 100;
    localparam int INIT = 15;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vending_if #(.N_ITEMS(4), .PRICE_W(8)) ifa ();
    vending_if #(.N_ITEMS(3), .PRICE_W(8)) ifb ();
    logic [1:0] st_a, st_b;

    vending_controller #(
        .N_ITEMS(4), .PRICE_W(8), .PRICES({8'd20, 8'd15, 8'd10, 8'd5}),
        .MAX_CREDIT(100), .STOCK_W(4), .INIT_STOCK(15)
    ) dut_a (.clk(clk), .rst(rst), .bus(ifa), .state_o(st_a));

    vending_controller #(
        .N_ITEMS(3), .PRICE_W(8), .PRICES({8'd20, 8'd10, 8'd5}),
        .MAX_CREDIT(100), .STOCK_W(4), .INIT_STOCK(1)
    ) dut_b (.clk(clk), .rst(rst), .bus(ifb), .state_o(st_b));

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model of dut_a ----------------
    int price_tab[N] = '{5, 10, 15, 20};
    int coin_val[4]  = '{1, 2, 5, 10};

    int m_credit;
    int m_stock[N];
    bit m_vend;      // dispense in progress this cycle
    int m_item;
    bit m_pay;       // paying out change
    bit e_rej, e_err;

    function automatic int greedy_m(input int c);
        for (int k = 3; k >= 0; k--) if (coin_val[k] <= c) return k;
        return 0;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_credit = 0;
            for (int i = 0; i < N; i++) m_stock[i] = INIT;
            m_vend = 0; m_pay = 0; m_item = 0; e_rej = 0; e_err = 0;
        end else begin
            e_rej = 0;
            e_err = 0;
            if (m_vend) begin
                m_stock[m_item] = m_stock[m_item] - 1;
                m_vend = 0;
                m_pay  = (m_credit > 0);
                e_rej  = ifa.coin_valid;
            end else if (m_pay) begin
                if (ifa.change_ready) begin
                    m_credit = m_credit - coin_val[greedy_m(m_credit)];
                    if (m_credit == 0) m_pay = 0;
                end
                e_rej = ifa.coin_valid;
            end else begin
                if (ifa.restock && m_credit == 0)
                    for (int i = 0; i < N; i++) m_stock[i] = INIT;
                if (ifa.cancel && m_credit > 0) begin
                    m_pay = 1;
                    e_rej = ifa.coin_valid;
                end else if (ifa.sel_valid) begin
                    e_rej = ifa.coin_valid;
                    if (int'(ifa.sel) < N && m_stock[ifa.sel] > 0 && m_credit >= price_tab[ifa.sel]) begin
                        m_credit = m_credit - price_tab[ifa.sel];
                        m_item   = int'(ifa.sel);
                        m_vend   = 1;
                    end else begin
                        e_err = 1;
                    end
                end else if (ifa.coin_valid) begin
                    if (m_credit + coin_val[ifa.coin] <= MAXC) m_credit = m_credit + coin_val[ifa.coin];
                    else e_rej = 1;
                end
            end
        end
    end

    // ---------------- compare process (dut_a vs model) ----------------
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            logic [N-1:0] exp_so;
            for (int i = 0; i < N; i++) exp_so[i] = (m_stock[i] == 0);
            chk("a_out", ifa.out, m_vend);
            if (m_vend) chk("a_out_item", ifa.out_item, m_item);
            chk("a_coin_reject", ifa.coin_reject, e_rej);
            chk("a_sel_err", ifa.sel_err, e_err);
            chk("a_change_valid", ifa.change_valid, m_pay);
            if (m_pay) chk("a_change_coin", ifa.change_coin, greedy_m(m_credit));
            chk("a_credit", ifa.credit, m_credit);
            chk("a_sold_out", ifa.sold_out, exp_so);
            chk("a_busy", ifa.busy, m_vend || m_pay);
        end
    end

    // ---------------- driver tasks (start and end on a falling edge) ----------------
    task automatic coin_a(input int code);
        ifa.coin_valid = 1'b1; ifa.coin = 2'(code);
        @(negedge clk);
        ifa.coin_valid = 1'b0;
    endtask

    task automatic sel_a(input int s);
        ifa.sel_valid = 1'b1; ifa.sel = 2'(s);
        @(negedge clk);
        ifa.sel_valid = 1'b0;
    endtask

    task automatic cancel_a();
        ifa.cancel = 1'b1;
        @(negedge clk);
        ifa.cancel = 1'b0;
    endtask

    task automatic drain_a();
        int n = 0;
        ifa.change_ready = 1'b1;
        while (ifa.busy === 1'b1 && n < 40) begin @(negedge clk); n++; end
        ifa.change_ready = 1'b0;
        chk("a_drain_busy", ifa.busy, 0);
    endtask

    task automatic coin_b(input int code);
        ifb.coin_valid = 1'b1; ifb.coin = 2'(code);
        @(negedge clk);
        ifb.coin_valid = 1'b0;
    endtask

    task automatic sel_b(input int s);
        ifb.sel_valid = 1'b1; ifb.sel = 2'(s);
        @(negedge clk);
        ifb.sel_valid = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        ifa.coin_valid = 0; ifa.coin = 0; ifa.sel_valid = 0; ifa.sel = 0;
        ifa.cancel = 0; ifa.restock = 0; ifa.change_ready = 0;
        ifb.coin_valid = 0; ifb.coin = 0; ifb.sel_valid = 0; ifb.sel = 0;
        ifb.cancel = 0; ifb.restock = 0; ifb.change_ready = 0;
        rst = 1'b1;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // reset state
        chk("rst_out", ifa.out, 0);
        chk("rst_credit", ifa.credit, 0);
        chk("rst_sold_out", ifa.sold_out, 0);
        chk("rst_change_valid", ifa.change_valid, 0);
        chk("rst_busy", ifa.busy, 0);
        chk("rst_b_sold_out", ifb.sold_out, 0);

        // exact-price purchase of item 3
        coin_a(3); coin_a(2); coin_a(2);
        chk("d1_credit", ifa.credit, 20);
        sel_a(3);
        chk("d1_out", ifa.out, 1);
        chk("d1_out_item", ifa.out_item, 3);
        chk("d1_credit_after", ifa.credit, 0);
        @(negedge clk);
        chk("d1_out_low", ifa.out, 0);
        chk("d1_no_change", ifa.change_valid, 0);
        chk("d1_busy", ifa.busy, 0);
        chk("d1_sold_out3", ifa.sold_out[3], 0);

        // purchase with change, first change coin held
        coin_a(3); coin_a(3);
        sel_a(0);
        chk("d2_out", ifa.out, 1);
        chk("d2_credit", ifa.credit, 15);
        @(negedge clk);
        chk("d2_cv", ifa.change_valid, 1);
        chk("d2_coin10", ifa.change_coin, 3);
        repeat (3) begin
            @(negedge clk);
            chk("d2_hold", ifa.change_coin, 3);
        end
        ifa.change_ready = 1'b1;
        @(negedge clk);
        chk("d2_credit5", ifa.credit, 5);
        chk("d2_coin5", ifa.change_coin, 2);
        @(negedge clk);
        ifa.change_ready = 1'b0;
        chk("d2_cv_done", ifa.change_valid, 0);
        chk("d2_credit0", ifa.credit, 0);

        // refused selection, then cancel
        coin_a(1); coin_a(0);
        sel_a(1);
        chk("d3_sel_err", ifa.sel_err, 1);
        chk("d3_credit", ifa.credit, 3);
        @(negedge clk);
        chk("d3_sel_err_low", ifa.sel_err, 0);
        cancel_a();
        chk("d3_cv", ifa.change_valid, 1);
        chk("d3_coin2", ifa.change_coin, 1);
        ifa.change_ready = 1'b1;
        @(negedge clk);
        chk("d3_coin1", ifa.change_coin, 0);
        chk("d3_credit1", ifa.credit, 1);
        @(negedge clk);
        ifa.change_ready = 1'b0;
        chk("d3_idle", ifa.busy, 0);
        chk("d3_credit0", ifa.credit, 0);

        // credit ceiling, coin during VEND
        repeat (10) coin_a(3);
        chk("d4_credit100", ifa.credit, 100);
        coin_a(0);
        chk("d4_reject", ifa.coin_reject, 1);
        chk("d4_credit_held", ifa.credit, 100);
        sel_a(0);
        chk("d4_vend", ifa.out, 1);
        coin_a(3);
        chk("d4_vend_reject", ifa.coin_reject, 1);
        chk("d4_credit95", ifa.credit, 95);
        drain_a();
        chk("d4_credit0", ifa.credit, 0);

        // asynchronous reset mid-change
        coin_a(3);
        cancel_a();
        chk("d5_cv", ifa.change_valid, 1);
        #2 rst = 1'b0;
        #1;
        chk("d5_rst_cv", ifa.change_valid, 0);
        chk("d5_rst_credit", ifa.credit, 0);
        chk("d5_rst_busy", ifa.busy, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // randomized traffic, checked every cycle by the model
        for (int c = 0; c < 3000; c++) begin
            ifa.coin_valid   = ($urandom_range(0, 99) < 30);
            ifa.coin         = 2'($urandom_range(0, 3));
            ifa.sel_valid    = ($urandom_range(0, 99) < 12);
            ifa.sel          = 2'($urandom_range(0, 3));
            ifa.cancel       = ($urandom_range(0, 99) < 4);
            ifa.restock      = ($urandom_range(0, 999) < 5);
            ifa.change_ready = ($urandom_range(0, 99) < 50);
            @(negedge clk);
        end
        ifa.coin_valid = 0; ifa.sel_valid = 0; ifa.cancel = 0; ifa.restock = 0;
        ifa.change_ready = 0;
        @(negedge clk);
        drain_a();

        // small-stock, 3-item instance
        coin_b(3); coin_b(3);
        sel_b(2);
        chk("b1_out", ifb.out, 1);
        chk("b1_out_item", ifb.out_item, 2);
        chk("b1_credit", ifb.credit, 0);
        @(negedge clk);
        chk("b1_sold_out", ifb.sold_out, 3'b100);
        coin_b(3); coin_b(3);
        sel_b(2);
        chk("b2_sel_err", ifb.sel_err, 1);
        chk("b2_credit", ifb.credit, 20);
        sel_b(3);
        chk("b3_range_err", ifb.sel_err, 1);
        chk("b3_credit", ifb.credit, 20);
        ifb.cancel = 1'b1;
        @(negedge clk);
        ifb.cancel = 1'b0;
        ifb.change_ready = 1'b1;
        for (int n = 0; n < 10 && ifb.busy === 1'b1; n++) @(negedge clk);
        ifb.change_ready = 1'b0;
        chk("b4_idle", ifb.busy, 0);
        chk("b4_credit", ifb.credit, 0);
        ifb.restock = 1'b1;
        @(negedge clk);
        ifb.restock = 1'b0;
        chk("b5_restocked", ifb.sold_out, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        fails++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/vending_controller.md
# vending_controller

Parametrised multi-item vending controller. It replaces the single-product, two-coin vending FSM with:
- N selectable items, each with its own price and stock counter;
- a saturating credit accumulator fed by four coin denominations;
- user cancel/refund;
- handshaked, one-coin-at-a-time change return.

It sits between the debounced front-panel inputs (coin acceptor, selection keys) and the dispense/change actuators.

## Interface
Parameters:
- N_ITEMS, 4, number of products (2..16).
- PRICE_W, 8, width of prices and credit.
- PRICES, {8'd20,8'd15,8'd10,8'd5}, packed N_ITEMS*PRICE_W vector. Item i price = PRICES[i*PRICE_W +: PRICE_W]. Every price must be nonzero.
- MAX_CREDIT, 100, credit ceiling; must be < 2**PRICE_W.
- STOCK_W, 4, width of each stock counter.
- INIT_STOCK, 15, stock loaded per item on reset/restock.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- coin_valid  in  1  one-cycle strobe: a coin is present.
- coin  in  2  denomination code: 0=1, 1=2, 2=5, 3=10 units.
- coin_reject  out  1  one-cycle pulse: the last strobed coin was not credited and is returned.
- sel_valid  in  1  one-cycle strobe: a selection is present.
- sel  in  $clog2(N_ITEMS)  item index.
- sel_err  out  1  one-cycle pulse: selection refused.
- cancel  in  1  refund request.
- restock  in  1  reload all stock counters.
- out  out  1  dispense pulse.
- out_item  out  $clog2(N_ITEMS)  item being dispensed; valid while out=1.
- change_valid  out  1  change coin offered.
- change_coin  out  2  change denomination, same encoding as coin.
- change_ready  in  1  actuator accepted the offered coin.
- credit  out  PRICE_W  current credit.
- sold_out  out  N_ITEMS  bit i = stock[i]==0.
- busy  out  1  high in VEND or CHANGE.

## Operation
- States: IDLE (credit=0), CREDIT (credit>0), VEND, CHANGE.
- **Priority in IDLE/CREDIT, per cycle:** cancel > sel_valid > coin_valid.
  - A coin strobed in the same cycle as an effective cancel or sel_valid is rejected.
  - A sel_valid while cancel is effective is ignored; no sel_err.
  - cancel with credit=0 has no effect; it then blocks neither sel_valid nor coin_valid.
- **Coin:** if credit+value ≤ MAX_CREDIT, credit += value and the state goes to CREDIT. Otherwise reject; credit is unchanged.
- **Selection** (sel_valid, no effective cancel): accepted when sel < N_ITEMS, stock[sel] > 0 and credit ≥ price[sel].
  - Accepted: credit -= price and the state goes to VEND.
  - Refused: sel_err pulses and the state and credit are unchanged.
- **Cancel** with credit>0 → CHANGE.
- **VEND:** lasts exactly one cycle. out=1 and out_item=latched sel. On exit, stock[out_item] decrements. Next state is CHANGE if credit>0, else IDLE.
- **CHANGE:** greedy payout.
  - change_coin = largest of {10,5,2,1} ≤ credit; change_valid=1.
  - On change_ready: credit -= value. When credit reaches 0 the state goes to IDLE, else the next coin is offered.
  - change_coin is held stable while change_valid && !change_ready.
- **While busy:** every coin is rejected; sel_valid, cancel and restock are ignored.
- **restock:** honoured only in IDLE. All stock counters are set to INIT_STOCK.
- **Arithmetic:** credit never exceeds MAX_CREDIT and never underflows. Stock never decrements below 0, because sold-out selections are refused.

## Timing
- **Reset** (rst low, asynchronous): state=IDLE, credit=0, every stock=INIT_STOCK. All outputs 0: out, out_item, coin_reject, sel_err, change_valid, change_coin, busy, sold_out. A reset during VEND or CHANGE abandons the operation; remaining credit is lost and no dispense or change follows.
- All outputs are registered.
- **Coin:** strobe sampled at edge N. credit or coin_reject is visible after edge N; coin_reject is high for one cycle.
- **Selection:** strobe sampled at edge N. After edge N: state=VEND, out=1, busy=1, and credit is already reduced. After edge N+1: out=0 and sold_out reflects the decremented stock.
- **First change coin:** change_valid rises after edge N+1 following VEND, or after edge N following an effective cancel.
- **Change handshake:** a handshake at edge M gives the next coin, or change_valid=0 with state IDLE, after edge M. One coin transfers per cycle at most.
- sel_err is high for one cycle after the edge that sampled the refused selection.

## Test plan
- Reset then release: all outputs 0, credit=0, sold_out=0. Assert rst mid-CHANGE: change_valid drops immediately and credit=0.
- Coins 10,5,5 (credit 20), sel=3 (price 20): out high one cycle with out_item=3. No change_valid, state returns to IDLE, sold_out[3]=0.
- Coins 10,10, sel=0 (price 5): out pulse, then change 10 then 5. Hold change_ready low 3 cycles on the first coin: change_coin stays 10. Final credit=0.
- Coins 2,1 (credit 3), sel=1 (price 10): sel_err pulse, credit stays 3. Then cancel: change coins 2 then 1, returning to IDLE.
- Ten coins of 10 (credit 100): the eleventh coin gives coin_reject and credit stays 100. A coin strobed during VEND is rejected.
- INIT_STOCK=1, buy item 2 twice with sufficient credit: the second attempt gives sel_err and sold_out[2]=1. restock in IDLE clears sold_out[2]. sel=N_ITEMS (when N_ITEMS=3) gives sel_err.
